// File: rtl/day11_edge_parser.sv
// day11_edge_parser: tokenizes "src: dst dst ...\n" byte streams into packed
// (src, dst) edge records delivered through a small valid/ready FIFO.
module day11_edge_parser #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_src,
    output logic [14:0]      out_dst,
    output logic             out_first,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] line_count,
    output logic             done,
    output logic             err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_SRC   = 3'd0;
    localparam logic [2:0] S_COLON = 3'd1;
    localparam logic [2:0] S_SP    = 3'd2;
    localparam logic [2:0] S_DST   = 3'd3;
    localparam logic [2:0] S_DEL   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]  state, ns_byte, ns;
    logic [1:0]  ncnt, ncnt_nx;
    logic [14:0] src, dst, src_nx, dst_nx;
    logic        first_pending, fp_nx;
    logic        push, line_inc, acc, push_q, pop;
    logic        is_let, is_nl, is_cr, is_sp, is_col;
    logic [4:0]  code;
    logic [30:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign is_let = (in_byte >= 8'h61) && (in_byte <= 8'h7a);
    assign is_nl  = in_byte == 8'h0a;
    assign is_cr  = in_byte == 8'h0d;
    assign is_sp  = in_byte == 8'h20;
    assign is_col = in_byte == 8'h3a;
    assign code   = 5'(in_byte - 8'h61);

    assign in_ready  = (state <= S_DEL) && (count < (AW+1)'(FIFO_DEPTH));
    assign acc       = in_valid & in_ready;
    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign push_q    = acc & push;
    assign err       = state == S_ERR;
    assign {out_src, out_dst, out_first} = out_valid ? mem[rd_ptr] : 31'd0;

    // Per-byte transition; error paths leave push/line_inc clear so a bad
    // byte never updates counters or the FIFO.
    always_comb begin
        ns_byte  = state;
        ncnt_nx  = ncnt;
        src_nx   = src;
        dst_nx   = dst;
        fp_nx    = first_pending;
        push     = 1'b0;
        line_inc = 1'b0;
        case (state)
            S_SRC: begin
                if (is_let) begin
                    src_nx  = {src[9:0], code};
                    ncnt_nx = (ncnt == 2'd2) ? 2'd0 : ncnt + 2'd1;
                    ns_byte = (ncnt == 2'd2) ? S_COLON : S_SRC;
                end else if (!((is_nl || is_cr) && ncnt == 2'd0)) begin
                    ns_byte = S_ERR;
                end
            end
            S_COLON: begin
                line_inc = is_col;
                fp_nx    = is_col ? 1'b1 : first_pending;
                ns_byte  = is_col ? S_SP : S_ERR;
            end
            S_SP: begin
                if (is_sp || is_cr) begin
                    ns_byte = S_SP;
                end else if (is_nl) begin
                    ns_byte = S_SRC;
                    ncnt_nx = 2'd0;
                end else if (is_let) begin
                    dst_nx  = {10'd0, code};
                    ncnt_nx = 2'd1;
                    ns_byte = S_DST;
                end else begin
                    ns_byte = S_ERR;
                end
            end
            S_DST: begin
                if (is_let) begin
                    dst_nx  = {dst[9:0], code};
                    push    = ncnt == 2'd2;
                    fp_nx   = (ncnt == 2'd2) ? 1'b0 : first_pending;
                    ncnt_nx = (ncnt == 2'd2) ? 2'd0 : ncnt + 2'd1;
                    ns_byte = (ncnt == 2'd2) ? S_DEL : S_DST;
                end else begin
                    ns_byte = S_ERR;
                end
            end
            S_DEL: begin
                ns_byte = (is_sp || is_cr) ? S_SP : is_nl ? S_SRC : S_ERR;
                ncnt_nx = 2'd0;
            end
            default: ns_byte = state;
        endcase
        // Final byte: only a clean token boundary may finish the stream.
        ns = !in_last ? ns_byte :
             (ns_byte == S_SP || ns_byte == S_DEL || (ns_byte == S_SRC && ncnt_nx == 2'd0)) ? S_DONE : S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_SRC;
            ncnt          <= 2'd0;
            src           <= '0;
            dst           <= '0;
            first_pending <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            edge_count    <= '0;
            line_count    <= '0;
            done          <= 1'b0;
        end else begin
            if (acc) begin
                state         <= ns;
                ncnt          <= ncnt_nx;
                src           <= src_nx;
                dst           <= dst_nx;
                first_pending <= fp_nx;
            end
            if (push_q) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count + {{AW{1'b0}}, push_q} - {{AW{1'b0}}, pop};
            edge_count <= edge_count + {{(CNT_W-1){1'b0}}, push_q & ~&edge_count};
            line_count <= line_count + {{(CNT_W-1){1'b0}}, acc & line_inc & ~&line_count};
            done       <= done | ((state == S_DONE || state == S_ERR) && count == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_q) mem[wr_ptr] <= {src, dst_nx, first_pending};
    end
endmodule

// File: tb/tb_day11_edge_parser.sv
// tb_day11_edge_parser: directed and random byte streams checked against a
// token-level reference parser kept in the bench.
module tb_day11_edge_parser;
    localparam int DEPTH = 4;
    localparam logic [7:0] NL = 8'h0a, CR = 8'h0d, SP = 8'h20, COL = 8'h3a;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, out_valid, out_first, done, err;
    logic [14:0] out_src, out_dst;
    logic [15:0] edge_count, line_count;

    int checks = 0, failures = 0;
    logic [7:0]  stim[$];
    logic [30:0] exp_q[$];
    int exp_n, exp_lines;
    bit exp_err;

    day11_edge_parser #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .out_dst(out_dst), .out_first(out_first),
        .edge_count(edge_count), .line_count(line_count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit name_ok(input int p);
        if (p + 2 >= stim.size()) return 0;
        for (int k = 0; k < 3; k++)
            if (stim[p+k] < 8'h61 || stim[p+k] > 8'h7a) return 0;
        return 1;
    endfunction

    function automatic logic [14:0] enc(input int p);
        return 15'((stim[p] - 97) * 1024 + (stim[p+1] - 97) * 32 + (stim[p+2] - 97));
    endfunction

    // Token-level grammar: optional blank lines, "nnn:" then separator-delimited names.
    task automatic model();
        int p, n;
        bit sep, first;
        logic [14:0] s;
        n = stim.size();
        p = 0;
        exp_q.delete();
        exp_lines = 0;
        exp_err = 0;
        while (p < n && !exp_err) begin
            if (stim[p] == NL || stim[p] == CR) begin
                p++;
            end else if (!name_ok(p) || p + 3 >= n || stim[p+3] != COL) begin
                exp_err = 1;
            end else begin
                s = enc(p);
                exp_lines++;
                p += 4;
                sep = 1;
                first = 1;
                while (p < n && !exp_err) begin
                    if (stim[p] == SP || stim[p] == CR) begin
                        sep = 1;
                        p++;
                    end else if (stim[p] == NL) begin
                        p++;
                        break;
                    end else if (!sep || !name_ok(p)) begin
                        exp_err = 1;
                    end else begin
                        exp_q.push_back({s, enc(p), first});
                        first = 0;
                        sep = 0;
                        p += 3;
                    end
                end
            end
        end
        exp_n = exp_q.size();
    endtask

    task automatic to_stim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic push_name();
        repeat (3) stim.push_back(8'($urandom_range(97, 100)));
    endtask

    task automatic gen();
        int nl, nd;
        stim.delete();
        nl = $urandom_range(1, 4);
        for (int l = 0; l < nl; l++) begin
            if ($urandom_range(3) == 0) stim.push_back($urandom_range(1) ? NL : CR);
            push_name();
            stim.push_back(COL);
            nd = $urandom_range(0, 5);
            for (int d = 0; d < nd; d++) begin
                if (d > 0 || $urandom_range(3) != 0)
                    repeat ($urandom_range(1, 2)) stim.push_back($urandom_range(4) == 0 ? CR : SP);
                push_name();
            end
            if (l < nl - 1 || $urandom_range(1) == 1) stim.push_back(NL);
        end
        if ($urandom_range(3) == 0) stim[$urandom_range(stim.size() - 1)] = 8'($urandom_range(32, 126));
        if ($urandom_range(5) == 0) stim.pop_back();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic feed(input bit last_en);
        bit ok;
        for (int i = 0; i < stim.size(); i++) begin
            in_byte  = stim[i];
            in_last  = last_en && (i == stim.size() - 1);
            in_valid = 1'b1;
            ok = 0;
            for (int k = 0; k < 500 && !ok && !err; k++) begin
                @(negedge clk);
                ok = in_ready;
            end
            if (!ok && !err) check("feed_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (!ok) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int pct, input int hold);
        bit fin;
        logic [30:0] e;
        fin = 0;
        for (int cy = 0; cy < 3000 && !fin; cy++) begin
            if (hold > 0 && cy == hold) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_edges", edge_count, (exp_n < DEPTH) ? exp_n : DEPTH);
            end
            @(negedge clk);
            if (done) begin
                fin = 1;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_rec", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rec", {out_src, out_dst, out_first}, e);
                end
            end
            @(posedge clk);
            #1 out_ready = (cy + 1 >= hold) && ($urandom_range(99) < pct);
        end
        if (!fin) check("drain_timeout", 0, 1);
        out_ready = 1'b0;
    endtask

    task automatic run(input int pct, input int hold);
        model();
        fork
            feed(1);
            drain(pct, hold);
        join
        check("edge_count", edge_count, exp_n);
        check("line_count", line_count, exp_lines);
        check("err", err, exp_err);
        check("done", done, 1);
        check("in_ready_end", in_ready, 0);
        check("missing_rec", exp_q.size(), 0);
        do_reset();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", {out_src, out_dst, out_first}, 0);
        check("rst_counts", {edge_count, line_count}, 0);
        check("rst_flags", {done, err}, 0);

        to_stim("you: bbb ccc\n");            run(100, 0);
        to_stim("aaa: bbb ccc ddd eee fff\n"); run(70, 40);
        to_stim("out:\n\r\n\nsvr: out");     run(100, 0);
        to_stim("yoU: out\n");                run(100, 0);
        to_stim("you: ou");                   run(100, 0);

        to_stim("aaa: bbb ccc");
        model();
        out_ready = 1'b0;
        feed(0);
        check("pre_rst_edges", edge_count, exp_n);
        do_reset();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_counts", {edge_count, line_count}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        to_stim("abc: def\n");                run(100, 0);

        for (int t = 0; t < 40; t++) begin
            gen();
            run($urandom_range(20, 100), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
